wb_m_pipe_master: RTL and testbench

WB_M_PIPE_MASTER -- requirements
Module: wb_m_pipe_master

---
 rtl/wb_m_pipe_master.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_wb_m_pipe_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_m_pipe_master.sv
// -----------------------------------------------------------------------------
// wb_m_pipe_master
// Command-driven Wishbone B4 pipelined master. Commands are queued in a
// command FIFO, issued on the bus with up to MAX_OUT requests in flight, and
// every access produces one response in issue order through a
// first-word-fall-through response FIFO. A bus error stops issuing; the rest of
// the bus cycle (up to the cmd_last command) is flushed with error responses.
//
// Optional feature: define WB_M_PIPE_MASTER_TIMEOUT_EN to compile in an ack
// watchdog that aborts the bus cycle after TIMEOUT_CYCLES silent cycles.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/addr/data/sel/last   command payload (last closes the bus cycle)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_err           read data (0 for writes), error/abort flag
//   wb_*_o / wb_*_i             Wishbone B4 pipelined master interface
//   busy                        FSM not idle or any FIFO non-empty
// -----------------------------------------------------------------------------
module wb_m_pipe_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int MAX_OUT        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    input  logic                    cmd_last,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i,
    output logic                    busy
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CPW   = $clog2(CMD_DEPTH);
    localparam int OW    = $clog2(MAX_OUT + 1);
    localparam int RPW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CMD_W = ADDR_WIDTH + DATA_WIDTH + SEL_W + 2;

    typedef enum logic [1:0] {IDLE, BUS, DRAIN, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic                    rdy_q;
    logic                    err_q, err_d;       // bus error seen this cycle
    logic                    last_q, last_d;     // cmd_last already issued
    logic                    to_q, to_d;         // watchdog abort in progress
    logic [OW-1:0]           outst_q, outst_d;
    logic [MAX_OUT-1:0]      inflight_we_q, inflight_we_d;

    logic [CMD_W-1:0]        cmd_mem_q [CMD_DEPTH];
    logic [CPW-1:0]          cmd_wptr_q, cmd_rptr_q;
    logic [CPW:0]            cmd_cnt_q, cmd_cnt_d;
    logic [DATA_WIDTH:0]     rsp_mem_q [MAX_OUT];
    logic [RPW-1:0]          rsp_wptr_q, rsp_rptr_q;
    logic [OW-1:0]           rsp_cnt_q, rsp_cnt_d;

    logic                    head_we, head_last;
    logic [ADDR_WIDTH-1:0]   head_adr;
    logic [DATA_WIDTH-1:0]   head_dat;
    logic [SEL_W-1:0]        head_sel;

    logic cmd_empty_s, cmd_full_s, cmd_push_s, cmd_pop_s;
    logic rsp_empty_s, rsp_full_s, rsp_push_s, rsp_pop_s;
    logic room_s, stb_s, issue_s, bus_rsp_s, to_drain_s, flush_pop_s, tmo_hit_s;
    logic [DATA_WIDTH:0] rsp_wdata_s;

    assign {head_we, head_adr, head_dat, head_sel, head_last} = cmd_mem_q[cmd_rptr_q];

    assign cmd_empty_s = (cmd_cnt_q == '0);
    assign cmd_full_s  = (cmd_cnt_q == (CPW+1)'(CMD_DEPTH));
    assign rsp_empty_s = (rsp_cnt_q == '0);
    assign rsp_full_s  = (rsp_cnt_q == OW'(MAX_OUT));

    // Requests in flight plus undelivered responses may never exceed MAX_OUT,
    // which is what keeps the response FIFO from overflowing.
    assign room_s = (({1'b0, outst_q} + {1'b0, rsp_cnt_q}) < (OW+1)'(MAX_OUT));

    // A same-cycle error also suppresses STB so nothing issues behind it.
    assign stb_s       = (state_q == BUS) && !cmd_empty_s && room_s && !err_q
                         && !to_q && !wb_err_i;
    assign issue_s     = stb_s && !wb_stall_i;
    assign bus_rsp_s   = (wb_ack_i || wb_err_i) && (outst_q != '0) && !to_q;
    assign to_drain_s  = to_q && (outst_q != '0);
    assign flush_pop_s = (state_q == FLUSH) && !cmd_empty_s && !rsp_full_s;

    assign cmd_ready  = rdy_q && !cmd_full_s;
    assign cmd_push_s = cmd_valid && cmd_ready;
    assign cmd_pop_s  = issue_s || flush_pop_s;
    assign rsp_push_s = bus_rsp_s || to_drain_s || flush_pop_s;
    assign rsp_pop_s  = !rsp_empty_s && rsp_ready;

    assign wb_cyc_o  = ((state_q == BUS) || (state_q == DRAIN)) && !to_q;
    assign wb_stb_o  = stb_s;
    assign wb_we_o   = stb_s ? head_we  : 1'b0;
    assign wb_adr_o  = stb_s ? head_adr : '0;
    assign wb_dat_o  = stb_s ? head_dat : '0;
    assign wb_sel_o  = stb_s ? head_sel : '0;

    assign rsp_valid = !rsp_empty_s;
    assign rsp_data  = rsp_empty_s ? '0   : rsp_mem_q[rsp_rptr_q][DATA_WIDTH:1];
    assign rsp_err   = rsp_empty_s ? 1'b0 : rsp_mem_q[rsp_rptr_q][0];
    assign busy      = (state_q != IDLE) || !cmd_empty_s || !rsp_empty_s;

`ifdef WB_M_PIPE_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_inc_s;

    assign tmo_inc_s = ((state_q == BUS) || (state_q == DRAIN)) && (outst_q != '0)
                       && !wb_ack_i && !wb_err_i && !to_q;
    assign tmo_hit_s = tmo_inc_s && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts silent cycles while requests are in flight.
    always_comb begin
        tmo_d = tmo_q;
        if (tmo_inc_s) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Response payload: read data only for reads; aborts carry zero data.
    always_comb begin
        rsp_wdata_s = {{DATA_WIDTH{1'b0}}, 1'b1};
        if (bus_rsp_s) begin
            rsp_wdata_s = {(inflight_we_q[0] ? {DATA_WIDTH{1'b0}} : wb_dat_i), wb_err_i};
        end else begin
            rsp_wdata_s = {{DATA_WIDTH{1'b0}}, 1'b1};
        end
    end

    // Counters, in-flight direction queue and FSM next state.
    always_comb begin
        logic          shift_v;
        logic [OW-1:0] idx_v;
        state_d       = state_q;
        err_d         = err_q;
        last_d        = last_q;
        to_d          = to_q;
        outst_d       = outst_q;
        cmd_cnt_d     = cmd_cnt_q;
        rsp_cnt_d     = rsp_cnt_q;
        inflight_we_d = inflight_we_q;
        shift_v       = bus_rsp_s || to_drain_s;
        idx_v         = shift_v ? (outst_q - OW'(1)) : outst_q;

        // Issue and completion in the same cycle cancel out.
        if (issue_s && !shift_v) begin
            outst_d = outst_q + OW'(1);
        end else if (!issue_s && shift_v) begin
            outst_d = outst_q - OW'(1);
        end else begin
            outst_d = outst_q;
        end

        // Direction bits of in-flight requests, oldest at bit 0.
        if (shift_v) begin
            inflight_we_d = inflight_we_q >> 1;
        end else begin
            inflight_we_d = inflight_we_q;
        end
        for (int i = 0; i < MAX_OUT; i++) begin
            if (issue_s && (OW'(i) == idx_v)) begin
                inflight_we_d[i] = head_we;
            end else begin
                inflight_we_d[i] = inflight_we_d[i];
            end
        end

        if (cmd_push_s && !cmd_pop_s) begin
            cmd_cnt_d = cmd_cnt_q + (CPW+1)'(1);
        end else if (!cmd_push_s && cmd_pop_s) begin
            cmd_cnt_d = cmd_cnt_q - (CPW+1)'(1);
        end else begin
            cmd_cnt_d = cmd_cnt_q;
        end

        if (rsp_push_s && !rsp_pop_s) begin
            rsp_cnt_d = rsp_cnt_q + OW'(1);
        end else if (!rsp_push_s && rsp_pop_s) begin
            rsp_cnt_d = rsp_cnt_q - OW'(1);
        end else begin
            rsp_cnt_d = rsp_cnt_q;
        end

        case (state_q)
            IDLE: begin
                err_d  = 1'b0;
                last_d = 1'b0;
                to_d   = 1'b0;
                if (!cmd_empty_s) begin
                    state_d = BUS;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (issue_s && head_last) begin
                    last_d = 1'b1;
                end else begin
                    last_d = last_q;
                end
                if (bus_rsp_s && wb_err_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (tmo_hit_s) begin
                    to_d = 1'b1;
                end else begin
                    to_d = to_q;
                end
                if ((issue_s && head_last) || (bus_rsp_s && wb_err_i) || tmo_hit_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = BUS;
                end
            end
            DRAIN: begin
                if (bus_rsp_s && wb_err_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (outst_q == '0) begin
                    to_d = 1'b0;
                    if ((err_q || to_q) && !last_q) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_hit_s) begin
                    to_d    = 1'b1;
                    state_d = DRAIN;
                end else begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (flush_pop_s && head_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state; reset also discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rdy_q         <= 1'b0;
            err_q         <= 1'b0;
            last_q        <= 1'b0;
            to_q          <= 1'b0;
            outst_q       <= '0;
            inflight_we_q <= '0;
            cmd_wptr_q    <= '0;
            cmd_rptr_q    <= '0;
            cmd_cnt_q     <= '0;
            rsp_wptr_q    <= '0;
            rsp_rptr_q    <= '0;
            rsp_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= 1'b1;
            err_q         <= err_d;
            last_q        <= last_d;
            to_q          <= to_d;
            outst_q       <= outst_d;
            inflight_we_q <= inflight_we_d;
            cmd_cnt_q     <= cmd_cnt_d;
            rsp_cnt_q     <= rsp_cnt_d;
            if (cmd_push_s) cmd_wptr_q <= cmd_wptr_q + CPW'(1);
            if (cmd_pop_s)  cmd_rptr_q <= cmd_rptr_q + CPW'(1);
            if (rsp_push_s) rsp_wptr_q <= (rsp_wptr_q == RPW'(MAX_OUT - 1)) ? '0 : rsp_wptr_q + RPW'(1);
            if (rsp_pop_s)  rsp_rptr_q <= (rsp_rptr_q == RPW'(MAX_OUT - 1)) ? '0 : rsp_rptr_q + RPW'(1);
        end
    end

    // FIFO storage; validity is tracked by the counters, so no reset needed.
    always_ff @(posedge clk) begin
        if (cmd_push_s) cmd_mem_q[cmd_wptr_q] <= {cmd_we, cmd_addr, cmd_data, cmd_sel, cmd_last};
        if (rsp_push_s) rsp_mem_q[rsp_wptr_q] <= rsp_wdata_s;
    end

endmodule

// File: tb/tb_wb_m_pipe_master.sv
module tb_wb_m_pipe_master;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel_b = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_last = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_data = 32'h0;
    logic [3:0]  cmd_sel = 4'hF;
    logic        rsp_ready = 1'b1;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_err, a_cyc, a_stb, a_we, a_busy;
    logic [31:0] a_rsp_data, a_adr, a_dat;
    logic [3:0]  a_sel;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we, b_busy;
    logic [31:0] b_rsp_data, b_adr, b_dat;
    logic [3:0]  b_sel;

    logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_cyc, o_stb, o_we, o_busy;
    logic [31:0] o_rsp_data, o_adr, o_dat;

    assign o_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
    assign o_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_err   = sel_b ? b_rsp_err   : a_rsp_err;
    assign o_rsp_data  = sel_b ? b_rsp_data  : a_rsp_data;
    assign o_cyc       = sel_b ? b_cyc : a_cyc;
    assign o_stb       = sel_b ? b_stb : a_stb;
    assign o_we        = sel_b ? b_we  : a_we;
    assign o_adr       = sel_b ? b_adr : a_adr;
    assign o_dat       = sel_b ? b_dat : a_dat;
    assign o_busy      = sel_b ? b_busy : a_busy;

    always #5 clk = ~clk;

    wb_m_pipe_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .MAX_OUT(4),
                       .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & ~sel_b), .cmd_ready(a_cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_last(cmd_last),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel_b), .rsp_data(a_rsp_data),
        .rsp_err(a_rsp_err), .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_we_o(a_we),
        .wb_adr_o(a_adr), .wb_dat_o(a_dat), .wb_sel_o(a_sel), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i & ~sel_b), .wb_err_i(wb_err_i & ~sel_b), .wb_stall_i(wb_stall_i),
        .busy(a_busy));

    wb_m_pipe_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .MAX_OUT(2),
                       .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & sel_b), .cmd_ready(b_cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_last(cmd_last),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel_b), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err), .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we),
        .wb_adr_o(b_adr), .wb_dat_o(b_dat), .wb_sel_o(b_sel), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i & sel_b), .wb_err_i(wb_err_i & sel_b), .wb_stall_i(wb_stall_i),
        .busy(b_busy));

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int slave_mode;      // 0 ack next cycle, 1 never ack, 2 error on first ack
    int stall_left, stb_cnt, issue_cnt, ack_idx;
    int first_ack, last_ack, first_rsp, first_stb, last_stb, last_cyc_hi, first_iss;
    cmd_t        cmd_q[$];
    logic [31:0] rd_data[$];
    logic [31:0] rsp_d_q[$];
    logic        rsp_e_q[$];
    logic [64:0] stb_log[$];

    task automatic clear_logs();
        slave_mode = 0; stall_left = 0; stb_cnt = 0; issue_cnt = 0; ack_idx = 0;
        first_ack = -1; last_ack = -1; first_rsp = -1; first_stb = -1; last_stb = -1;
        last_cyc_hi = -1; first_iss = -1;
        cmd_q.delete(); rd_data.delete(); rsp_d_q.delete(); rsp_e_q.delete(); stb_log.delete();
        wb_stall_i = 1'b0; rsp_ready = 1'b1;
    endtask

    task automatic add_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic last);
        cmd_t c;
        c.we = we; c.addr = addr; c.data = data; c.last = last;
        cmd_q.push_back(c);
    endtask

    task automatic drive_cmd();
        if (cmd_q.size() > 0) begin
            cmd_valid = 1'b1; cmd_we = cmd_q[0].we; cmd_addr = cmd_q[0].addr;
            cmd_data = cmd_q[0].data; cmd_last = cmd_q[0].last;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // One clock: observe outputs at posedge+2, then drive the slave and commands.
    task automatic step();
        logic iss;
        iss = o_cyc && o_stb && !wb_stall_i;
        if (o_stb) begin
            stb_cnt++;
            stb_log.push_back({o_we, o_adr, o_dat});
            if (first_stb < 0) first_stb = cyc_n;
            last_stb = cyc_n;
            if (wb_stall_i && stall_left > 0) stall_left--;
        end
        if (iss) begin
            issue_cnt++;
            if (first_iss < 0) first_iss = cyc_n;
        end
        if (o_cyc) last_cyc_hi = cyc_n;
        if (o_rsp_valid && first_rsp < 0) first_rsp = cyc_n;
        if (o_rsp_valid && rsp_ready) begin
            rsp_d_q.push_back(o_rsp_data);
            rsp_e_q.push_back(o_rsp_err);
        end
        if (cmd_valid && o_cmd_ready) void'(cmd_q.pop_front());
        @(posedge clk);
        #1;
        cyc_n++;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        if (iss && slave_mode != 1) begin
            if (slave_mode == 2 && ack_idx == 0) wb_err_i = 1'b1;
            else wb_ack_i = 1'b1;
            if (ack_idx < rd_data.size()) wb_dat_i = rd_data[ack_idx];
            ack_idx++;
            if (first_ack < 0) first_ack = cyc_n;
            last_ack = cyc_n;
        end
        wb_stall_i = (stall_left > 0);
        drive_cmd();
        #1;
    endtask

    task automatic apply_reset();
        cmd_valid = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        #3;
        total++; if (o_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b exp=0", o_cyc); end
        total++; if (o_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b exp=0", o_stb); end
        total++; if (o_cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", o_cmd_ready); end
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", o_rsp_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        total++; if ({a_adr, a_dat, a_sel, a_we} !== 69'h0) begin bad++; $display("FAIL rst_bus_zero got=%h exp=0", {a_adr, a_dat, a_sel, a_we}); end
        total++; if ({a_rsp_data, a_rsp_err} !== 33'h0) begin bad++; $display("FAIL rst_rsp_zero got=%h exp=0", {a_rsp_data, a_rsp_err}); end
        @(posedge clk); #1 rst_n = 1'b1; #1;
        total++; if (o_cmd_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_pre got=%b exp=0", o_cmd_ready); end
        @(posedge clk); #2;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rel_ready_post got=%b exp=1", o_cmd_ready); end
    endtask

    task automatic test_read_burst();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            add_cmd(1'b0, 32'h10 + 32'(4 * i), 32'h0, (i == 3));
            rd_data.push_back(32'h11 * 32'(i + 1));
        end
        drive_cmd();
        repeat (14) step();
        total++; if (stb_cnt !== 4) begin bad++; $display("FAIL burst_stb_cnt got=%0d exp=4", stb_cnt); end
        total++; if (last_stb - first_stb !== 3) begin bad++; $display("FAIL burst_stb_span got=%0d exp=3", last_stb - first_stb); end
        total++; if (rsp_d_q.size() !== 4) begin bad++; $display("FAIL burst_rsp_cnt got=%0d exp=4", rsp_d_q.size()); end
        for (int i = 0; i < rsp_d_q.size(); i++) begin
            total++;
            if ({rsp_d_q[i], rsp_e_q[i]} !== {32'h11 * 32'(i + 1), 1'b0}) begin
                bad++; $display("FAIL burst_rsp%0d got=%h/%b exp=%h/0", i, rsp_d_q[i], rsp_e_q[i], 32'h11 * 32'(i + 1));
            end
        end
        total++; if (first_rsp !== first_ack + 1) begin bad++; $display("FAIL burst_latency got=%0d exp=%0d", first_rsp, first_ack + 1); end
        total++; if (last_cyc_hi !== last_ack + 1) begin bad++; $display("FAIL burst_cyc_drop got=%0d exp=%0d", last_cyc_hi, last_ack + 1); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL burst_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_stall_write();
        clear_logs();
        add_cmd(1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        stall_left = 3; wb_stall_i = 1'b1;
        drive_cmd();
        repeat (12) step();
        total++; if (stb_cnt !== 4) begin bad++; $display("FAIL stall_stb_cnt got=%0d exp=4", stb_cnt); end
        total++; if (issue_cnt !== 1) begin bad++; $display("FAIL stall_issue got=%0d exp=1", issue_cnt); end
        for (int i = 0; i < stb_log.size(); i++) begin
            total++;
            if (stb_log[i] !== {1'b1, 32'h100, 32'hDEADBEEF}) begin
                bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, stb_log[i], {1'b1, 32'h100, 32'hDEADBEEF});
            end
        end
        total++; if (rsp_d_q.size() !== 1) begin bad++; $display("FAIL stall_rsp_cnt got=%0d exp=1", rsp_d_q.size()); end
        if (rsp_d_q.size() > 0) begin
            total++; if ({rsp_d_q[0], rsp_e_q[0]} !== 33'h0) begin bad++; $display("FAIL stall_rsp got=%h/%b exp=0/0", rsp_d_q[0], rsp_e_q[0]); end
        end
    endtask

    task automatic test_err_flush();
        clear_logs();
        slave_mode = 2;
        for (int i = 0; i < 3; i++) add_cmd(1'b0, 32'h200 + 32'(4 * i), 32'h0, (i == 2));
        drive_cmd();
        repeat (14) step();
        total++; if (issue_cnt !== 1) begin bad++; $display("FAIL err_issue got=%0d exp=1", issue_cnt); end
        total++; if (rsp_d_q.size() !== 3) begin bad++; $display("FAIL err_rsp_cnt got=%0d exp=3", rsp_d_q.size()); end
        if (rsp_d_q.size() > 0) begin
            total++; if (rsp_e_q[0] !== 1'b1) begin bad++; $display("FAIL err_bus_rsp got=%b exp=1", rsp_e_q[0]); end
        end
        for (int i = 1; i < rsp_d_q.size(); i++) begin
            total++;
            if ({rsp_d_q[i], rsp_e_q[i]} !== {32'h0, 1'b1}) begin
                bad++; $display("FAIL err_flush%0d got=%h/%b exp=0/1", i, rsp_d_q[i], rsp_e_q[i]);
            end
        end
        total++; if ({o_cyc, o_busy} !== 2'b00) begin bad++; $display("FAIL err_idle got=%b exp=00", {o_cyc, o_busy}); end
    endtask

    task automatic test_max_out();
        clear_logs();
        sel_b = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            add_cmd(1'b0, 32'h300 + 32'(4 * i), 32'h0, (i == 3));
            rd_data.push_back(32'hA1 + 32'(i));
        end
        rsp_ready = 1'b0;
        drive_cmd();
        repeat (10) step();
        total++; if (issue_cnt !== 2) begin bad++; $display("FAIL maxout_held got=%0d exp=2", issue_cnt); end
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL maxout_rsp_valid got=%b exp=1", o_rsp_valid); end
        rsp_ready = 1'b1;
        repeat (16) step();
        total++; if (issue_cnt !== 4) begin bad++; $display("FAIL maxout_resume got=%0d exp=4", issue_cnt); end
        total++; if (rsp_d_q.size() !== 4) begin bad++; $display("FAIL maxout_rsp_cnt got=%0d exp=4", rsp_d_q.size()); end
        for (int i = 0; i < rsp_d_q.size(); i++) begin
            total++;
            if ({rsp_d_q[i], rsp_e_q[i]} !== {32'hA1 + 32'(i), 1'b0}) begin
                bad++; $display("FAIL maxout_rsp%0d got=%h/%b exp=%h/0", i, rsp_d_q[i], rsp_e_q[i], 32'hA1 + 32'(i));
            end
        end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL maxout_busy got=%b exp=0", o_busy); end
        sel_b = 1'b0;
        #1;
    endtask

`ifdef WB_M_PIPE_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        clear_logs();
        slave_mode = 1;
        add_cmd(1'b0, 32'h400, 32'h0, 1'b1);
        drive_cmd();
        repeat (30) step();
        total++; if (last_cyc_hi !== first_iss + 16) begin bad++; $display("FAIL tmo_cyc_drop got=%0d exp=%0d", last_cyc_hi, first_iss + 16); end
        total++; if (rsp_d_q.size() !== 1) begin bad++; $display("FAIL tmo_rsp_cnt got=%0d exp=1", rsp_d_q.size()); end
        if (rsp_d_q.size() > 0) begin
            total++; if ({rsp_d_q[0], rsp_e_q[0]} !== {32'h0, 1'b1}) begin bad++; $display("FAIL tmo_rsp got=%h/%b exp=0/1", rsp_d_q[0], rsp_e_q[0]); end
        end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b exp=0", o_busy); end
    endtask
`else
    task automatic test_no_timeout();
        clear_logs();
        slave_mode = 1;
        add_cmd(1'b0, 32'h400, 32'h0, 1'b0);
        add_cmd(1'b0, 32'h404, 32'h0, 1'b1);
        drive_cmd();
        repeat (40) step();
        total++; if (issue_cnt !== 2) begin bad++; $display("FAIL hang_issue got=%0d exp=2", issue_cnt); end
        total++; if (o_cyc !== 1'b1) begin bad++; $display("FAIL hang_cyc got=%b exp=1", o_cyc); end
        total++; if (rsp_d_q.size() !== 0) begin bad++; $display("FAIL hang_rsp got=%0d exp=0", rsp_d_q.size()); end
        apply_reset();
        total++; if (o_cyc !== 1'b0) begin bad++; $display("FAIL hang_recover got=%b exp=0", o_cyc); end
    endtask
`endif

    task automatic test_reset_mid();
        clear_logs();
        slave_mode = 1;
        add_cmd(1'b0, 32'h500, 32'h0, 1'b0);
        add_cmd(1'b0, 32'h504, 32'h0, 1'b1);
        drive_cmd();
        repeat (6) step();
        total++; if (issue_cnt !== 2) begin bad++; $display("FAIL rmid_issue got=%0d exp=2", issue_cnt); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({o_cyc, o_stb, o_busy, o_rsp_valid} !== 4'b0000) begin
            bad++; $display("FAIL rmid_async got=%b exp=0000", {o_cyc, o_stb, o_busy, o_rsp_valid});
        end
        @(posedge clk); #1 rst_n = 1'b1; #1;
        total++; if (o_cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_pre got=%b exp=0", o_cmd_ready); end
        @(posedge clk); #2;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_post got=%b exp=1", o_cmd_ready); end
        repeat (5) step();
        total++; if ({o_cyc, o_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rmid_quiet got=%b exp=00", {o_cyc, o_rsp_valid}); end
        total++; if (rsp_d_q.size() !== 0) begin bad++; $display("FAIL rmid_no_rsp got=%0d exp=0", rsp_d_q.size()); end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_read_burst();
        test_stall_write();
        test_err_flush();
        test_max_out();
`ifdef WB_M_PIPE_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
